exec_alu_stage: RTL and testbench
=================================

Name: exec_alu_stage

Overview:
Execute stage directly downstream of readmemory (register-file read). Consumes the read1/read2 operand pair plus decoded op and destination address. Produces a registered result with a write-back address for the register file.
- Single-cycle ALU ops.
- Iterative shift-add multiply (optional).
- valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand/result width; matches read1/read2.
- ADDR_W, 2, register address width; matches rs1/rs2.
- SHAMT_W, 5, shift-amount bits taken from read2[SHAMT_W-1:0].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  op/operands/rd valid this cycle.
- in_ready  out  1  stage can accept this cycle.
- op  in  3  operation code (see Behaviour).
- rd  in  ADDR_W  destination register address.
- read1  in  WIDTH  operand A from register file port 1.
- read2  in  WIDTH  operand B from register file port 2.
- out_valid  out  1  result/out_rd/out_wr valid.
- out_ready  in  1  downstream (write-back) accepts.
- result  out  WIDTH  registered result.
- out_rd  out  ADDR_W  destination address for result.
- out_wr  out  1  write-enable qualifier for register file.
- zero  out  1  result == 0.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE, out_valid=0, result=0, out_rd=0, out_wr=0, zero=1, mul counter=0.
  - Takes priority over every other event.
- in_ready (combinational) = (state==IDLE) && (!out_valid || out_ready).
- Acceptance occurs at an edge where in_valid && in_ready.
- Op codes:
  - 000 ADD, wrap mod 2^WIDTH.
  - 001 SUB, A-B wrap.
  - 010 AND; 011 OR; 100 XOR.
  - 101 SLT: signed compare, result 1 or 0.
  - 110 SLL: A << read2[SHAMT_W-1:0]; upper bits of read2 ignored.
  - 111 MUL: low WIDTH bits of A*B, unsigned.
- ALU ops (000-110):
  - On the acceptance edge, load result, out_rd=rd, out_wr=1, zero, and set out_valid=1.
  - Latency 1 cycle.
  - Throughput 1 per cycle when out_ready held high.
- FSM states: IDLE, MUL.
  - IDLE -> MUL on acceptance of op 111 (MUL_EN defined).
  - On that edge: latch multiplicand=A, multiplier=B, acc=0, count=0, rd latched; out_valid cleared (slot was free or draining).
  - MUL, each edge:
    - if multiplier[0], acc += multiplicand;
    - multiplicand <<= 1; multiplier >>= 1; count++.
  - On the edge where count==WIDTH-1: result=final acc, out_valid=1, out_wr=1, out_rd=latched rd, state -> IDLE.
  - out_valid rises exactly WIDTH cycles after the acceptance edge; in_ready=0 throughout MUL.
  - Early termination is not permitted (fixed latency).
- Output hold:
  - While out_valid && !out_ready, result/out_rd/out_wr/zero are frozen.
  - out_valid clears on an edge with out_ready && !(new acceptance).
- Simultaneous out handshake and new ALU acceptance: new result overwrites the slot, out_valid stays 1.
- Reset mid-MUL: multiply aborted, no result emitted, in_ready=1 on the first cycle after rst drops.
- in_valid while in_ready=0: ignored; the upstream holds its inputs.

Optional Feature:
- Macro: EXEC_MUL_EN.
- Defined: op 111 is the iterative multiply as above.
- Undefined:
  - no MUL state or datapath is synthesised.
  - op 111 is accepted as a 1-cycle NOP: result=0, zero=1, out_wr=0, out_valid=1.

Decomposition:
- Package exec_pkg:
  - op code localparams (OP_ADD..OP_MUL);
  - FSM state encoding (ST_IDLE, ST_MUL);
  - default WIDTH/ADDR_W constants shared with readmemory.
- One sub-module, exec_mul_iter: shift-add multiplier with start/done, WIDTH-cycle latency.
  - Instantiated only under EXEC_MUL_EN.

Test Plan:
- ADD A=0x7FFFFFFF B=0x00000001 rd=2 -> result 0x80000000, zero=0, out_rd=2, out_wr=1, out_valid one cycle after acceptance.
- SUB 5-5 -> result 0, zero=1. SLT A=0xFFFFFFFF B=1 -> result 1. SLL A=1 B=0x21 -> result 0x2.
- MUL 12345*678 -> result 0x007FB6F6.
  - out_valid exactly 32 cycles after acceptance, in_ready=0 for all of those cycles.
  - MUL 0x00010000*0x00010000 -> 0, zero=1.
- Backpressure:
  - ADD result pending with out_ready=0 for 3 cycles -> result stable, in_ready=0.
  - Then out_ready=1 with in_valid back-to-back XOR ops -> one result per cycle.
- rst pulsed when MUL count=10 -> out_valid stays 0, no result emitted, in_ready=1 the cycle after rst drops.
  - A following ADD 3+4 -> 7 at latency 1.
- Without EXEC_MUL_EN: op 111 A=3 B=4 -> result 0, out_wr=0, out_valid after 1 cycle.

Source files
------------

// File: rtl/exec_pkg.sv
// ============================================================================
// Module      : exec_pkg
// Description : Shared op codes, FSM encoding and default widths for the
//               execute stage (widths match readmemory).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exec_pkg;

   localparam int EXEC_WIDTH   = 32;
   localparam int EXEC_ADDR_W  = 2;
   localparam int EXEC_SHAMT_W = 5;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;
   localparam logic [2:0] OP_SLL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MUL  = 1'b1;

endpackage : exec_pkg

`default_nettype wire

// File: rtl/exec_mul_iter.sv
// ============================================================================
// Module      : exec_mul_iter
// Description : Iterative shift-add multiplier, low WIDTH bits of an unsigned
//               product, fixed WIDTH-cycle latency from start to done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] prod_o
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [WIDTH-1:0] acc_q;
   logic [CNT_W-1:0] count_q;
   logic             busy_q;
   logic [WIDTH-1:0] acc_d;

   // The final step's partial product is folded into prod_o so the top can
   // capture the completed product on the same edge that ends the run.
   always_comb begin
      acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
      done_o = busy_q && (count_q == LAST_CNT);
      prod_o = acc_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         count_q  <= '0;
         busy_q   <= 1'b0;
      end else if (start_i) begin
         mcand_q  <= a_i;
         mplier_q <= b_i;
         acc_q    <= '0;
         count_q  <= '0;
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         count_q  <= count_q + 1'b1;
         if (done_o) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule : exec_mul_iter

`default_nettype wire

// File: rtl/exec_alu_stage.sv
// ============================================================================
// Module      : exec_alu_stage
// Description : Execute stage after readmemory: single-cycle ALU with a
//               registered, handshaked result slot. Define EXEC_MUL_EN to
//               build op 111 as an iterative multiply (else it is a NOP).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_alu_stage
   import exec_pkg::*;
#(
   parameter int WIDTH   = EXEC_WIDTH,
   parameter int ADDR_W  = EXEC_ADDR_W,
   parameter int SHAMT_W = EXEC_SHAMT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        op,
   input  logic [ADDR_W-1:0] rd,
   input  logic [WIDTH-1:0]  read1,
   input  logic [WIDTH-1:0]  read2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  result,
   output logic [ADDR_W-1:0] out_rd,
   output logic              out_wr,
   output logic              zero
);

   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  result_q,    result_d;
   logic [ADDR_W-1:0] out_rd_q,    out_rd_d;
   logic              out_wr_q,    out_wr_d;
   logic              zero_q,      zero_d;
   logic [WIDTH-1:0]  alu_res;
   logic              accept;
   logic              slot_free;

   assign slot_free = !out_valid_q || out_ready;
   assign accept    = in_valid && in_ready;

   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD:  alu_res = read1 + read2;
         OP_SUB:  alu_res = read1 - read2;
         OP_AND:  alu_res = read1 & read2;
         OP_OR:   alu_res = read1 | read2;
         OP_XOR:  alu_res = read1 ^ read2;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(read1) < $signed(read2))};
         OP_SLL:  alu_res = read1 << read2[SHAMT_W-1:0];
         default: alu_res = '0;
      endcase
   end

`ifdef EXEC_MUL_EN
   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] mul_rd_q, mul_rd_d;
   logic              mul_start;
   logic              mul_done;
   logic [WIDTH-1:0]  mul_prod;

   assign mul_start = accept && (op == OP_MUL);

   exec_mul_iter #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start_i (mul_start),
      .a_i     (read1),
      .b_i     (read2),
      .done_o  (mul_done),
      .prod_o  (mul_prod)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         mul_rd_q <= '0;
      end else begin
         state_q  <= state_d;
         mul_rd_q <= mul_rd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (mul_start) state_d = ST_MUL;
         ST_MUL:  if (mul_done)  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == ST_IDLE) && slot_free;
   end
`else
   always_comb begin
      in_ready = slot_free;
   end
`endif

   always_comb begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      out_rd_d    = out_rd_q;
      out_wr_d    = out_wr_q;
      zero_d      = zero_q;
`ifdef EXEC_MUL_EN
      mul_rd_d    = mul_rd_q;
`endif

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
`ifdef EXEC_MUL_EN
         if (op == OP_MUL) begin
            out_valid_d = 1'b0;
            mul_rd_d    = rd;
         end else begin
            result_d    = alu_res;
            out_rd_d    = rd;
            out_wr_d    = 1'b1;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
         end
`else
         // op 111 still occupies the slot but must not write the register file
         result_d    = alu_res;
         out_rd_d    = rd;
         out_wr_d    = (op != OP_MUL);
         zero_d      = (alu_res == '0);
         out_valid_d = 1'b1;
`endif
      end

`ifdef EXEC_MUL_EN
      if (mul_done) begin
         result_d    = mul_prod;
         out_rd_d    = mul_rd_q;
         out_wr_d    = 1'b1;
         zero_d      = (mul_prod == '0);
         out_valid_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         out_rd_q    <= '0;
         out_wr_q    <= 1'b0;
         zero_q      <= 1'b1;
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         out_rd_q    <= out_rd_d;
         out_wr_q    <= out_wr_d;
         zero_q      <= zero_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign out_rd    = out_rd_q;
   assign out_wr    = out_wr_q;
   assign zero      = zero_q;

endmodule : exec_alu_stage

`default_nettype wire

// File: tb/tb_exec_alu_stage.sv
// ============================================================================
// Module      : tb_exec_alu_stage
// Description : Scoreboard bench for exec_alu_stage; MUL vectors are used
//               when EXEC_MUL_EN is defined, the op 111 NOP vector otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exec_alu_stage;
   import exec_pkg::*;

   typedef struct packed {
      logic [31:0] res;
      logic [1:0]  rd;
      logic        wr;
      logic        z;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [1:0]  rd;
   logic [31:0] read1;
   logic [31:0] read2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [1:0]  out_rd;
   logic        out_wr;
   logic        zero;

   int   n_vec   = 0;
   int   n_fail  = 0;
   int   stalls  = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   exec_alu_stage #(.WIDTH(32), .ADDR_W(2), .SHAMT_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .rd        (rd),
      .read1     (read1),
      .read2     (read2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .out_rd    (out_rd),
      .out_wr    (out_wr),
      .zero      (zero)
   );

   // Monitor: every completed output handshake is checked against the queue.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         exp_t e;
         n_vec++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output got result=%h rd=%0d wr=%0d zero=%0d",
                     result, out_rd, out_wr, zero);
         end else begin
            e = q.pop_front();
            if ({result, out_rd, out_wr, zero} !== e) begin
               n_fail++;
               $display("FAIL output got result=%h rd=%0d wr=%0d zero=%0d exp result=%h rd=%0d wr=%0d zero=%0d",
                        result, out_rd, out_wr, zero, e.res, e.rd, e.wr, e.z);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] r, input bit push, input exp_t e);
      int t = 0;
      @(negedge clk);
      while (!in_ready && t < 100) begin
         stalls++;
         t++;
         @(negedge clk);
      end
      if (!in_ready) begin
         n_vec++;
         n_fail++;
         $display("FAIL issue_timeout got in_ready=0 exp in_ready=1 within 100 cycles");
         return;
      end
      op = o; read1 = a; read2 = b; rd = r; in_valid = 1'b1;
      if (push) q.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   initial begin
      int bad;
      int got_j;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      op = OP_ADD; rd = '0; read1 = '0; read2 = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_result",    result,             32'd0);
      chk("rst_rd_wr_z",   {29'b0, out_rd, out_wr, zero}, 32'b0001);
      rst = 1'b0;
      chk("rst_in_ready",  {31'b0, in_ready},  32'd1);

      issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 2'd2, 1, '{32'h8000_0000, 2'd2, 1'b1, 1'b0});
      chk("add_latency1", {31'b0, out_valid}, 32'd1);
      issue(OP_SUB, 32'd5, 32'd5, 2'd1, 1, '{32'h0, 2'd1, 1'b1, 1'b1});
      issue(OP_SLT, 32'hFFFF_FFFF, 32'h1, 2'd3, 1, '{32'h1, 2'd3, 1'b1, 1'b0});
      issue(OP_AND, 32'hF0F0, 32'hFF00, 2'd0, 1, '{32'hF000, 2'd0, 1'b1, 1'b0});
      issue(OP_OR,  32'hF0F0, 32'hFF00, 2'd1, 1, '{32'hFFF0, 2'd1, 1'b1, 1'b0});
      issue(OP_SLL, 32'h1, 32'h21, 2'd2, 1, '{32'h2, 2'd2, 1'b1, 1'b0});

      // Backpressure: pending ADD held for 3 cycles
      @(posedge clk);
      #1 out_ready = 1'b0;
      issue(OP_ADD, 32'd10, 32'd20, 2'd1, 1, '{32'd30, 2'd1, 1'b1, 1'b0});
      repeat (3) begin
         @(negedge clk);
         chk("bp_valid",    {31'b0, out_valid}, 32'd1);
         chk("bp_result",   result,             32'd30);
         chk("bp_in_ready", {31'b0, in_ready},  32'd0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      stalls = 0;
      issue(OP_XOR, 32'hFF, 32'h0F, 2'd0, 1, '{32'hF0, 2'd0, 1'b1, 1'b0});
      issue(OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 2'd1, 1, '{32'h5555_5555, 2'd1, 1'b1, 1'b0});
      issue(OP_XOR, 32'h1234, 32'h1234, 2'd2, 1, '{32'h0, 2'd2, 1'b1, 1'b1});
      chk("xor_back_to_back_stalls", stalls, 32'd0);

`ifdef EXEC_MUL_EN
      issue(OP_MUL, 32'd12345, 32'd678, 2'd3, 1, '{32'h007F_B6F6, 2'd3, 1'b1, 1'b0});
      bad = 0; got_j = 0;
      for (int j = 1; j <= 40; j++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin got_j = j; break; end
         if (in_ready) bad++;
         if (j == 1) begin op = OP_ADD; read1 = 32'd1; read2 = 32'd1; in_valid = 1'b1; end
         if (j == 20) in_valid = 1'b0;
      end
      chk("mul_latency",      got_j, 32'd32);
      chk("mul_in_ready_low", bad,   32'd0);
      issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, 2'd1, 1, '{32'h0, 2'd1, 1'b1, 1'b1});

      // Abort a multiply once its counter reaches 10
      issue(OP_MUL, 32'd7, 32'd9, 2'd2, 0, '0);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("mulrst_in_ready",  {31'b0, in_ready},  32'd1);
      chk("mulrst_out_valid", {31'b0, out_valid}, 32'd0);
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) bad++;
      end
      chk("mulrst_no_result", bad, 32'd0);
`else
      issue(OP_MUL, 32'd3, 32'd4, 2'd2, 1, '{32'h0, 2'd2, 1'b0, 1'b1});
      chk("nop_latency1", {31'b0, out_valid}, 32'd1);
`endif

      // Reset drops a result stuck behind backpressure
      @(negedge clk);
      @(posedge clk);
      #1 out_ready = 1'b0;
      issue(OP_ADD, 32'd1, 32'd1, 2'd3, 0, '0);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0; out_ready = 1'b1;
      chk("rst_pending_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_pending_z",     {31'b0, zero},      32'd1);

      issue(OP_ADD, 32'd3, 32'd4, 2'd2, 1, '{32'd7, 2'd2, 1'b1, 1'b0});
      chk("add_after_rst_latency1", {31'b0, out_valid}, 32'd1);

      for (int t = 0; t < 200 && q.size() != 0; t++) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_drained", q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule : tb_exec_alu_stage

`default_nettype wire
